wb_cmd_master: RTL and testbench
================================

// Module: wb_cmd_master
// PURPOSE
//  Synthesizable Wishbone classic single-transfer master; the stage directly upstream of a WB slave/memory.
//  Accepts one command (adr/dat/sel/we) on a valid/ready port and runs one WB cycle.
//  Terminates the cycle on ack/err/rty, with bounded retry and timeout.
//  Returns read data and status on a valid/ready response port. One transaction in flight.
// PARAMETERS
//  MAX_RETRY  3   rty terminations re-issued before giving up (0 = no retry)
//  RETRY_GAP  2   idle cycles (cyc low) between an rty and the re-issue; >=1
//  TIMEOUT    64  max cycles stb may stay high without termination; >=2
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst         in   1   asynchronous reset, active-low
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   command accepted when cmd_valid&cmd_ready at posedge
//  cmd_adr     in   32  byte address
//  cmd_dat     in   32  write data
//  cmd_sel     in   4   byte selects
//  cmd_we      in   1   1=write, 0=read
//  rsp_valid   out  1   response present, held until rsp_ready
//  rsp_ready   in   1   response consumed when rsp_valid&rsp_ready at posedge
//  rsp_dat     out  32  read data (0 for writes and for failed reads)
//  rsp_status  out  2   00 ok, 01 err, 10 retry exhausted, 11 timeout
//  wb_adr_o    out  32  WB address
//  wb_dat_o    out  32  WB write data
//  wb_dat_i    in   32  WB read data
//  wb_sel_o    out  4   WB byte selects
//  wb_we_o     out  1   WB write enable; 0 whenever wb_cyc_o=0
//  wb_cyc_o    out  1   WB cycle
//  wb_stb_o    out  1   WB strobe; always equal to wb_cyc_o
//  wb_ack_i    in   1   WB normal termination
//  wb_err_i    in   1   WB error termination
//  wb_rty_i    in   1   WB retry termination
// BEHAVIOUR
//  Reset (rst low, async): state IDLE; every output 0, incl. cmd_ready, retry and timeout counters.
//  All outputs are registered. cmd_ready=1 exactly while in IDLE, from the 1st posedge after reset release.
//  FSM: IDLE -> BUS -> {RESP | GAP}; GAP -> BUS; RESP -> IDLE.
//  IDLE: on accept, latch cmd_* into wb_*_o; retry_cnt=0; enter BUS; cyc/stb rise the next cycle.
//  BUS: cyc=stb=1; adr/dat/sel/we held stable. tmo_cnt increments every cycle; it clears on each BUS entry.
//  Termination is sampled at posedge with priority err > ack > rty; a simultaneous ack and rty count as ack.
//   ack: rsp_dat = we ? 0 : wb_dat_i; status 00; go to RESP.
//   err: rsp_dat=0; status 01; go to RESP.
//   rty: if retry_cnt<MAX_RETRY, increment retry_cnt and go to GAP; else rsp_dat=0, status 10, go to RESP.
//   No termination while tmo_cnt==TIMEOUT-1: status 11; go to RESP. stb stays high for exactly TIMEOUT cycles.
//  cyc/stb drop in the cycle after the terminating edge. A zero-wait slave therefore gives a 1-cycle stb pulse.
//  GAP: cyc=stb=0 for RETRY_GAP cycles, then BUS again with the same latched command.
//  RESP: rsp_valid=1; rsp_dat and rsp_status are stable until rsp_ready. On handshake go to IDLE; rsp_valid=0 next cycle.
//  Throughput: with a 0-wait slave and rsp_ready=1, accept-to-accept is 3 cycles (IDLE, BUS, RESP).
//  Reset mid-cycle: cyc/stb drop asynchronously; in-flight command and response are discarded, nothing is replayed.
//  A cmd_valid held during BUS/GAP/RESP is not accepted (cmd_ready=0) and must be held stable by the source.
// TESTING
//  Bench slave = WB memory model, delay 0. Write 0x1234_5678 to 0x100, sel=F, then read 0x100
//   -> read returns 0x1234_5678, status 00; each stb lasts 1 cycle.
//  Slave delay 3. Write sel=4'b0011 data 0xAAAA_BBBB over 0xFFFF_0000, then read
//   -> read returns 0xFFFF_BBBB; stb high 4 cycles per transfer.
//  Slave drives rty on every cycle, MAX_RETRY=3, RETRY_GAP=2 -> 4 stb pulses, 2-cycle gaps, status 10, rsp_dat 0.
//  Slave never terminates, TIMEOUT=64 -> stb high exactly 64 cycles, status 11; next cmd accepted normally.
//  err together with ack on the same edge -> status 01. rsp_ready held low 10 cycles
//   -> rsp_valid/rsp_status stable and cmd_ready=0 throughout.
//  rst asserted mid BUS while the slave inserts wait states -> cyc/stb 0 immediately, rsp_valid 0;
//   after release a fresh read succeeds.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// rtl/wb_cmd_master_if.sv - command, response and Wishbone signal bundle for wb_cmd_master
interface wb_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        cmd_we;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    modport master (
        input  cmd_valid, cmd_adr, cmd_dat, cmd_sel, cmd_we, rsp_ready,
               wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_status,
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );

    modport slave (
        output cmd_valid, cmd_adr, cmd_dat, cmd_sel, cmd_we, rsp_ready,
               wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_status,
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic single-transfer master with retry and timeout
module wb_cmd_master #(
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic            clk,
    input  logic            rst,
    wb_cmd_master_if.master bus
);
    localparam int CNT_MAX = (TIMEOUT > RETRY_GAP) ? TIMEOUT : RETRY_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRY + 2);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(RETRY_GAP - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [31:0]   adr_q, adr_d, dat_q, dat_d, rsp_dat_q, rsp_dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [1:0]    status_q, status_d;
    logic          we_q, we_d, wbwe_q, wbwe_d;
    logic          cyc_q, cyc_d, ready_q, ready_d, rsp_valid_q, rsp_valid_d;
    logic          accept;

    // ready_q is only ever high in IDLE, so it alone qualifies acceptance
    assign accept = ready_q & bus.cmd_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            wbwe_q      <= 1'b0;
            cyc_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            wbwe_q      <= wbwe_d;
            cyc_q       <= cyc_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            status_q    <= status_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = BUS;
            BUS: begin
                if (bus.wb_err_i || bus.wb_ack_i)
                    state_d = RESP;
                else if (bus.wb_rty_i)
                    state_d = (retry_q < RETRY_LIM) ? GAP : RESP;
                else if (cnt_q == TMO_LAST)
                    state_d = RESP;
            end
            GAP:  if (cnt_q == GAP_LAST) state_d = BUS;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = '0;
        retry_d   = retry_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        rsp_dat_d = rsp_dat_q;
        status_d  = status_q;
        if (accept) begin
            adr_d   = bus.cmd_adr;
            dat_d   = bus.cmd_dat;
            sel_d   = bus.cmd_sel;
            we_d    = bus.cmd_we;
            retry_d = '0;
        end
        // one counter serves both the timeout in BUS and the idle gap in GAP
        if ((state_d == state_q) && ((state_q == BUS) || (state_q == GAP)))
            cnt_d = cnt_q + 1'b1;
        if ((state_q == BUS) && (state_d == GAP))
            retry_d = retry_q + 1'b1;
        if ((state_q == BUS) && (state_d == RESP)) begin
            rsp_dat_d = '0;
            if (bus.wb_err_i) begin
                status_d = 2'b01;
            end else if (bus.wb_ack_i) begin
                status_d  = 2'b00;
                rsp_dat_d = we_q ? 32'd0 : bus.wb_dat_i;
            end else if (bus.wb_rty_i) begin
                status_d = 2'b10;
            end else begin
                status_d = 2'b11;
            end
        end
        cyc_d       = (state_d == BUS);
        wbwe_d      = (state_d == BUS) & we_d;
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    assign bus.cmd_ready  = ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_dat    = rsp_dat_q;
    assign bus.rsp_status = status_q;
    assign bus.wb_adr_o   = adr_q;
    assign bus.wb_dat_o   = dat_q;
    assign bus.wb_sel_o   = sel_q;
    assign bus.wb_we_o    = wbwe_q;
    assign bus.wb_cyc_o   = cyc_q;
    assign bus.wb_stb_o   = cyc_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - randomized self-checking bench for wb_cmd_master
module tb_wb_cmd_master;
    localparam int MR = 3;
    localparam int RG = 2;
    localparam int TO = 64;
    localparam int S_MEM = 0, S_RTY = 1, S_NONE = 2, S_ERRACK = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_cmd_master_if bus ();

    wb_cmd_master #(.MAX_RETRY(MR), .RETRY_GAP(RG), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          smode    = S_MEM;
    int          sdelay   = 0;
    int          wait_cnt = 0;
    logic        mem_clr  = 1'b1;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    // Slave: memory with programmable wait states, or a fixed misbehaviour
    always_comb begin
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_rty_i = 1'b0;
        if (bus.wb_cyc_o && bus.wb_stb_o) begin
            case (smode)
                S_MEM:    bus.wb_ack_i = (wait_cnt == sdelay);
                S_RTY:    bus.wb_rty_i = 1'b1;
                S_ERRACK: begin bus.wb_err_i = 1'b1; bus.wb_ack_i = 1'b1; end
                default:  ;
            endcase
        end
    end

    assign bus.wb_dat_i = mem[bus.wb_adr_o[9:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i && !bus.wb_err_i && bus.wb_we_o) begin
            for (int b = 0; b < 4; b++)
                if (bus.wb_sel_o[b]) mem[bus.wb_adr_o[9:2]][8*b +: 8] <= bus.wb_dat_o[8*b +: 8];
        end
        if (bus.wb_cyc_o && !(bus.wb_ack_i || bus.wb_err_i || bus.wb_rty_i))
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    // Strobe pulse lengths and the idle gaps between retries
    int   pulse_q[$];
    int   gap_q[$];
    int   run_len   = 0;
    int   low_cnt   = 0;
    bit   low_clean = 1'b0;
    logic prev_stb  = 1'b0;

    always @(negedge clk) begin
        if (bus.wb_stb_o) begin
            if (!prev_stb) begin
                if (low_clean) gap_q.push_back(low_cnt);
                run_len = 0;
            end
            run_len++;
        end else begin
            if (prev_stb) begin
                pulse_q.push_back(run_len);
                low_cnt   = 0;
                low_clean = 1'b1;
            end
            low_cnt++;
            if (bus.cmd_ready || bus.rsp_valid) low_clean = 1'b0;
        end
        prev_stb = bus.wb_stb_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("stb_eq_cyc", 32'(bus.wb_stb_o), 32'(bus.wb_cyc_o));
        if (!bus.wb_cyc_o) chk("we_low_idle", 32'(bus.wb_we_o), 32'd0);
    endtask

    task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic w, input int mode,
                           input int dly, input int hold);
        logic [31:0] exp_dat;
        logic [1:0]  exp_st;
        int exp_pulses, exp_len, p0, g0, n, idx;
        idx    = int'(a[9:2]);
        smode  = mode;
        sdelay = dly;
        case (mode)
            S_MEM:   begin exp_st = 2'b00; exp_dat = w ? 32'd0 : ref_mem[idx]; exp_pulses = 1;      exp_len = dly + 1; end
            S_RTY:   begin exp_st = 2'b10; exp_dat = 32'd0;                      exp_pulses = MR + 1; exp_len = 1;       end
            S_NONE:  begin exp_st = 2'b11; exp_dat = 32'd0;                      exp_pulses = 1;      exp_len = TO;      end
            default: begin exp_st = 2'b01; exp_dat = 32'd0;                      exp_pulses = 1;      exp_len = 1;       end
        endcase
        p0 = pulse_q.size();
        g0 = gap_q.size();

        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 300) begin tick(); n++; end
        chk({tag, "_ready_wait"}, 32'(n < 300), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_adr   = a;
        bus.cmd_dat   = d;
        bus.cmd_sel   = s;
        bus.cmd_we    = w;
        tick();
        bus.cmd_valid = 1'b0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 300) begin tick(); n++; end
        chk({tag, "_rsp_wait"}, 32'(n < 300), 32'd1);
        chk({tag, "_dat"}, bus.rsp_dat, exp_dat);
        chk({tag, "_status"}, 32'(bus.rsp_status), 32'(exp_st));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, "_hold_dat"}, bus.rsp_dat, exp_dat);
            chk({tag, "_hold_status"}, 32'(bus.rsp_status), 32'(exp_st));
            chk({tag, "_hold_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);

        chk({tag, "_pulses"}, 32'(pulse_q.size() - p0), 32'(exp_pulses));
        for (int i = p0; i < pulse_q.size(); i++) chk({tag, "_pulse_len"}, 32'(pulse_q[i]), 32'(exp_len));
        chk({tag, "_gaps"}, 32'(gap_q.size() - g0), (mode == S_RTY) ? 32'(MR) : 32'd0);
        for (int i = g0; i < gap_q.size(); i++) chk({tag, "_gap_len"}, 32'(gap_q[i]), 32'(RG));

        if (mode == S_MEM && w)
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    initial begin
        int last, cnt, r, mode;
        logic [31:0] a;
        bus.cmd_valid = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_dat   = '0;
        bus.cmd_sel   = '0;
        bus.cmd_we    = 1'b0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        repeat (3) tick();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_dat", bus.rsp_dat, 32'd0);
        chk("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
        chk("rst_adr", bus.wb_adr_o, 32'd0);
        chk("rst_wdat", bus.wb_dat_o, 32'd0);
        chk("rst_sel", 32'(bus.wb_sel_o), 32'd0);
        chk("rst_we", 32'(bus.wb_we_o), 32'd0);
        chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
        mem_clr = 1'b0;
        rst     = 1'b1;
        #1;
        chk("ready_at_release", 32'(bus.cmd_ready), 32'd0);
        tick();
        chk("ready_after_edge", 32'(bus.cmd_ready), 32'd1);

        run_txn("zw_wr", 32'h100, 32'h1234_5678, 4'hF, 1'b1, S_MEM, 0, 0);
        run_txn("zw_rd", 32'h100, 32'h0, 4'hF, 1'b0, S_MEM, 0, 0);
        run_txn("ws_wr1", 32'h104, 32'hFFFF_0000, 4'hF, 1'b1, S_MEM, 3, 0);
        run_txn("ws_wr2", 32'h104, 32'hAAAA_BBBB, 4'b0011, 1'b1, S_MEM, 3, 0);
        run_txn("ws_rd", 32'h104, 32'h0, 4'hF, 1'b0, S_MEM, 3, 0);
        chk("ws_merge_word", ref_mem[65], 32'hFFFF_BBBB);
        run_txn("rty", 32'h108, 32'h0, 4'hF, 1'b0, S_RTY, 0, 0);
        run_txn("tmo", 32'h108, 32'h0, 4'hF, 1'b0, S_NONE, 0, 0);
        run_txn("after_tmo", 32'h100, 32'h0, 4'hF, 1'b0, S_MEM, 0, 0);
        run_txn("err_ack", 32'h100, 32'h0, 4'hF, 1'b0, S_ERRACK, 0, 10);

        // back-to-back reads with a zero-wait slave and an always-ready consumer
        smode = S_MEM;
        sdelay = 0;
        bus.cmd_adr   = 32'h100;
        bus.cmd_we    = 1'b0;
        bus.cmd_sel   = 4'hF;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        last = -1;
        cnt  = 0;
        for (int t = 0; t < 20 && cnt < 4; t++) begin
            if (bus.rsp_valid === 1'b1) chk("tput_dat", bus.rsp_dat, ref_mem[64]);
            if (bus.cmd_ready === 1'b1) begin
                if (last >= 0) chk("tput_interval", 32'(t - last), 32'd3);
                last = t;
                cnt++;
                if (cnt == 4) bus.cmd_valid = 1'b0;
            end
            if (cnt < 4) tick();
        end
        chk("tput_accepts", 32'(cnt), 32'd4);
        tick();
        bus.rsp_ready = 1'b0;

        // reset while the slave is inserting wait states
        sdelay = 8;
        bus.cmd_valid = 1'b1;
        bus.cmd_adr   = 32'h100;
        bus.cmd_we    = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_stb", 32'(bus.wb_stb_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_stb", 32'(bus.wb_stb_o), 32'd0);
        chk("mid_rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_replay_stb", 32'(bus.wb_stb_o), 32'd0);
            chk("no_replay_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        run_txn("post_rst_rd", 32'h100, 32'h0, 4'hF, 1'b0, S_MEM, 1, 0);

        for (int k = 0; k < 24; k++) begin
            r = int'($urandom_range(0, 9));
            mode = (r <= 6) ? S_MEM : (r == 7) ? S_RTY : (r == 8) ? S_ERRACK : S_NONE;
            a = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
            run_txn("rnd", a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    mode, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
